// File: rtl/uart_tl_pkg.sv
// Shared UART/TileLink bridge definitions: packet geometry and assembler states.
package uart_tl_pkg;
  localparam int unsigned PKT_BYTES  = 16;
  localparam int unsigned PKT_BITS   = 128;
  localparam int unsigned BYTE_IDX_W = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } pkt_state_t;
endpackage

// File: rtl/uart_pkt_sat_counter.sv
// Saturating up-counter with synchronous clear, used for assembler diagnostics.
module uart_pkt_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         sysclk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge sysclk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_packet_assembler.sv
// Gathers 16 UART bytes into a 128-bit packet (byte 0 at LSBs) behind valid/ready.
// Optional inter-byte timeout resync is enabled by defining UART_PKT_TIMEOUT_EN.
module uart_packet_assembler
  import uart_tl_pkg::*;
#(
  parameter int unsigned PKT_BYTES      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                sysclk,
  input  logic                reset,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  output logic                packet_valid,
  input  logic                packet_ready,
  output logic [PKT_BITS-1:0] packet_data,
  output logic                busy,
  output logic [CNT_W-1:0]    overrun_count,
  output logic [CNT_W-1:0]    timeout_count
);

  pkt_state_t            state;
  logic [BYTE_IDX_W-1:0] byte_cnt;
  logic                  timeout_fire;
  logic                  last_byte;
  logic                  overrun_inc;

  assign last_byte   = (byte_cnt == BYTE_IDX_W'(PKT_BYTES - 1));
  assign busy        = (state == COLLECT) && (byte_cnt != '0);
  assign overrun_inc = (state == HOLD) && rx_valid;

`ifdef UART_PKT_TIMEOUT_EN
  localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [IDLE_W-1:0] idle_cnt;
  logic              idle_expired;

  assign idle_expired = (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout_fire = busy && !rx_valid && idle_expired;

  always_ff @(posedge sysclk) begin
    if (reset || !busy || rx_valid || idle_expired) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  // Timeout hardware absent; parameter retained so overrides stay portable.
  assign timeout_fire = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state        <= COLLECT;
      byte_cnt     <= '0;
      packet_data  <= '0;
      packet_valid <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (rx_valid) begin
            packet_data[{byte_cnt, 3'b000} +: 8] <= rx_data;
            if (last_byte) begin
              state        <= HOLD;
              packet_valid <= 1'b1;
              byte_cnt     <= '0;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end else if (timeout_fire) begin
            byte_cnt <= '0;
          end
        end
        HOLD: begin
          if (packet_ready) begin
            state        <= COLLECT;
            packet_valid <= 1'b0;
          end
        end
        default: begin
          state        <= COLLECT;
          packet_valid <= 1'b0;
        end
      endcase
    end
  end

  uart_pkt_sat_counter #(.W(CNT_W)) u_overrun_cnt (
    .sysclk (sysclk),
    .clear  (reset),
    .inc    (overrun_inc),
    .count  (overrun_count)
  );

  uart_pkt_sat_counter #(.W(CNT_W)) u_timeout_cnt (
    .sysclk (sysclk),
    .clear  (reset),
    .inc    (timeout_fire),
    .count  (timeout_count)
  );

endmodule

// File: tb/tb_uart_packet_assembler.sv
// Directed bench for uart_packet_assembler; timeout expectations follow UART_PKT_TIMEOUT_EN.
module tb_uart_packet_assembler;

  logic         sysclk;
  logic         reset;
  logic         rx_valid;
  logic [7:0]   rx_data;
  logic         packet_valid;
  logic         packet_ready;
  logic [127:0] packet_data;
  logic         busy;
  logic [7:0]   overrun_count;
  logic [7:0]   timeout_count;

  int unsigned vectors;
  int unsigned miscompares;

  uart_packet_assembler #(
    .PKT_BYTES      (16),
    .TIMEOUT_CYCLES (20),
    .CNT_W          (8)
  ) dut (
    .sysclk        (sysclk),
    .reset         (reset),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .packet_valid  (packet_valid),
    .packet_ready  (packet_ready),
    .packet_data   (packet_data),
    .busy          (busy),
    .overrun_count (overrun_count),
    .timeout_count (timeout_count)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge, so checks here see post-edge state.
  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_run(input logic [7:0] base, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) send_byte(base + 8'(i));
  endtask

  function automatic logic [127:0] ramp_pkt(input logic [7:0] base);
    logic [127:0] p;
    for (int unsigned k = 0; k < 16; k++) p[8*k +: 8] = base + 8'(k);
    return p;
  endfunction

  initial begin
    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b1;
    rx_valid     = 1'b0;
    rx_data      = 8'h00;
    packet_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_valid",   128'(packet_valid),  128'd0);
    check("reset_busy",    128'(busy),          128'd0);
    check("reset_overrun", 128'(overrun_count), 128'd0);
    check("reset_timeout", 128'(timeout_count), 128'd0);
    check("reset_data",    packet_data,         128'd0);

    // Basic assembly with the consumer always ready.
    packet_ready = 1'b1;
    send_run(8'h00, 15);
    check("basic_busy15",  128'(busy),         128'd1);
    check("basic_valid15", 128'(packet_valid), 128'd0);
    send_byte(8'h0F);
    check("basic_valid16", 128'(packet_valid), 128'd1);
    check("basic_data",    packet_data, 128'h0F0E0D0C0B0A09080706050403020100);
    check("basic_busy16",  128'(busy),         128'd0);
    tick();
    check("basic_onecyc",  128'(packet_valid), 128'd0);

    // Backpressure: packet held, bytes in HOLD dropped.
    packet_ready = 1'b0;
    send_run(8'h10, 16);
    check("bp_valid", 128'(packet_valid), 128'd1);
    repeat (50) tick();
    check("bp_hold50", 128'(packet_valid), 128'd1);
    send_run(8'hE0, 3);
    check("bp_overrun", 128'(overrun_count), 128'd3);
    check("bp_data",    packet_data, 128'h1F1E1D1C1B1A19181716151413121110);
    packet_ready = 1'b1;
    tick();
    check("bp_handshake", 128'(packet_valid), 128'd0);
    packet_ready = 1'b0;
    send_run(8'h20, 16);
    check("bp_next_valid", 128'(packet_valid), 128'd1);
    check("bp_next_data",  packet_data, 128'h2F2E2D2C2B2A29282726252423222120);

    // Byte arriving on the handshake cycle is dropped.
    packet_ready = 1'b1;
    send_byte(8'hAA);
    check("coll_valid",   128'(packet_valid),  128'd0);
    check("coll_overrun", 128'(overrun_count), 128'd4);
    check("coll_busy",    128'(busy),          128'd0);
    packet_ready = 1'b0;
    send_run(8'h30, 16);
    check("coll_data", packet_data, ramp_pkt(8'h30));
    packet_ready = 1'b1;
    tick();
    check("coll_release", 128'(packet_valid), 128'd0);

    // Partial packet then a long idle gap.
    packet_ready = 1'b0;
    send_run(8'h40, 5);
    repeat (25) tick();
`ifdef UART_PKT_TIMEOUT_EN
    check("to_busy",    128'(busy),          128'd0);
    check("to_count",   128'(timeout_count), 128'd1);
    send_run(8'h50, 15);
    check("to_valid15", 128'(packet_valid),  128'd0);
    send_byte(8'h5F);
    check("to_valid",   128'(packet_valid),  128'd1);
    check("to_data",    packet_data, ramp_pkt(8'h50));
`else
    check("nto_busy",   128'(busy),          128'd1);
    check("nto_count",  128'(timeout_count), 128'd0);
    send_run(8'h45, 10);
    check("nto_valid15", 128'(packet_valid), 128'd0);
    send_byte(8'h4F);
    check("nto_valid",  128'(packet_valid),  128'd1);
    check("nto_data",   packet_data, 128'h4F4E4D4C4B4A49484746454443424140);
`endif
    packet_ready = 1'b1;
    tick();
    check("to_release", 128'(packet_valid), 128'd0);

    // Reset mid-packet discards everything, including counters.
    packet_ready = 1'b0;
    send_run(8'h60, 9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_valid",   128'(packet_valid),  128'd0);
    check("rst_busy",    128'(busy),          128'd0);
    check("rst_overrun", 128'(overrun_count), 128'd0);
    check("rst_timeout", 128'(timeout_count), 128'd0);
    check("rst_data",    packet_data,         128'd0);
    send_run(8'h70, 15);
    check("rst_valid15", 128'(packet_valid), 128'd0);
    send_byte(8'h7F);
    check("rst_pkt_valid", 128'(packet_valid), 128'd1);
    check("rst_pkt_data",  packet_data, ramp_pkt(8'h70));

    // Overrun counter saturates instead of wrapping.
    send_run(8'h00, 260);
    check("sat_overrun", 128'(overrun_count), 128'd255);
    check("sat_data",    packet_data, ramp_pkt(8'h70));
    packet_ready = 1'b1;
    tick();
    check("sat_release", 128'(packet_valid), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_packet_assembler.md
Name: uart_packet_assembler

Overview:
- Sits between the UART receiver byte stream and uart_to_tilelink_bridge, in the sysclk domain.
- Collects 16 consecutive received bytes into one 128-bit packet, byte 0 at the LSBs, matching the host's struct.pack("<BBBBLQ") layout.
- Presents the packet on a valid/ready handshake and holds it until accepted.
- Resynchronises after host aborts with an inter-byte timeout, and counts dropped bytes.

Parameters:
- PKT_BYTES, 16, bytes per packet; only 16 is supported.
- TIMEOUT_CYCLES, 100000, idle sysclk cycles after which a partial packet is discarded. Must be greater than 1 UART byte time, which is 8681 cycles at 100 MHz / 115200 baud.
- CNT_W, 8, width of the saturating diagnostic counters.

Ports:
- sysclk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- rx_valid  input  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  input  8  received byte.
- packet_valid  output  1  assembled packet available.
- packet_ready  input  1  consumer accepts the packet.
- packet_data  output  128  packet; byte k at [8k+7:8k].
- busy  output  1  high when a partial packet is in progress (byte_cnt != 0) in COLLECT.
- overrun_count  output  CNT_W  bytes dropped while in HOLD; saturating.
- timeout_count  output  CNT_W  partial packets discarded by timeout; saturating.

Behaviour:
- Reset (sampled at a sysclk edge) clears all state:
  - state=COLLECT, byte_cnt=0, idle counter=0, packet_data=0.
  - packet_valid=0, busy=0, both counters=0.
  - Reset mid-packet or mid-HOLD loses the data with no handshake. packet_valid is 0 from the cycle after reset is sampled.
- States: COLLECT, HOLD. packet_valid = (state==HOLD), driven from a register.
- COLLECT, on rx_valid:
  - Write rx_data into byte lane byte_cnt.
  - If byte_cnt==15: go to HOLD and clear byte_cnt to 0.
  - Else: byte_cnt++.
  - Latency: packet_valid rises the cycle after the 16th rx_valid.
- HOLD:
  - packet_data is stable and no lane is written.
  - The cycle packet_valid && packet_ready returns to COLLECT. packet_ready is ignored in COLLECT.
  - rx_valid in HOLD, including on the handshake cycle itself, drops the byte and increments overrun_count. Such a byte is never written into the next packet.
- Lanes not yet written in a new packet keep their previous contents. The consumer only sees the packet after all 16 lanes are rewritten.
- Counters saturate at 2^CNT_W-1; they do not wrap.
- Both outputs are stable between events.

Optional Feature:
- Macro UART_PKT_TIMEOUT_EN.
- Defined:
  - In COLLECT with byte_cnt!=0, the idle counter increments each cycle without rx_valid and clears on rx_valid.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_valid that cycle: byte_cnt=0, idle counter=0, timeout_count++.
  - If rx_valid coincides with the expiry cycle, the byte is accepted and no timeout occurs.
  - The idle counter is held at 0 in HOLD and when byte_cnt==0.
- Undefined: no idle counter is built, partial packets persist indefinitely, and timeout_count is tied to 0.

Decomposition:
- Package uart_tl_pkg holds:
  - PKT_BYTES=16, PKT_BITS=128, BYTE_IDX_W=4.
  - State enum {COLLECT, HOLD}.
  - This package is shared with uart_to_tilelink_bridge and the future response packer.
- One sub-module, uart_pkt_sat_counter (parameter W; inputs inc and clear), instantiated for overrun_count and timeout_count.

Test Plan:
- Basic assembly: send bytes 0x00,0x01,…,0x0F with packet_ready=1 → packet_valid high for exactly 1 cycle, starting the cycle after the 16th strobe. packet_data=128'h0F0E0D0C0B0A09080706050403020100.
- Backpressure: hold packet_ready=0 for 50 cycles after assembly, then send 3 more bytes → packet_data is unchanged and overrun_count=3. Raise ready: handshake occurs, then the next 16 bytes form a clean packet.
- Handshake-cycle collision: drive rx_valid with 0xAA on the same cycle as valid&&ready → byte dropped, overrun_count=1. The next packet's byte 0 is the following byte, not 0xAA.
- Timeout (UART_PKT_TIMEOUT_EN, TIMEOUT_CYCLES=20): send 5 bytes, then idle 25 cycles → busy falls, timeout_count=1. The next 16 bytes yield one correct packet.
- Timeout disabled build: same stimulus → no discard. The next 11 bytes complete the packet, using the original 5 as bytes 0–4.
- Reset mid-packet: send 9 bytes, pulse reset for 1 cycle, then send 16 bytes → exactly one packet, equal to the 16 post-reset bytes. All counters read 0 after reset.
